// File: rtl/ttc_interrupt_ctrl.sv
// Triple-timer-counter interrupt aggregator: edge/level capture into a raw status
// register, enable masking, W1C and clear-all, plus count/timeout event coalescing.
module ttc_interrupt_ctrl #(
  parameter int NUM_SRC     = 6,
  parameter int SYNC_STAGES = 1,
  parameter int CNT_W       = 4,
  parameter int TMO_W       = 8
) (
  input  logic               pclk,
  input  logic               n_p_reset,
  input  logic [31:0]        pwdata,
  input  logic               intr_en_reg_sel,
  input  logic               intr_mode_reg_sel,
  input  logic               intr_clr_sel,
  input  logic               clear_interrupt,
  input  logic               coal_reg_sel,
  input  logic [NUM_SRC-1:0] intr_src,
  output logic               interrupt,
  output logic [NUM_SRC-1:0] interrupt_reg_out,
  output logic [NUM_SRC-1:0] interrupt_raw_out,
  output logic [NUM_SRC-1:0] interrupt_en_out,
  output logic [NUM_SRC-1:0] interrupt_mode_out,
  output logic [CNT_W-1:0]   coal_cnt_out
);

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

  logic [NUM_SRC-1:0] s, s_d, evt, clr_vec;
  logic [NUM_SRC-1:0] raw_q, en_q, mode_q;
  logic               interrupt_set;
  logic [CNT_W-1:0]   thresh_q, cnt_q, cnt_n;
  logic [TMO_W-1:0]   tmo_q, timer_q, timer_n;
  state_t             state_q, state_n;
  logic               ev_en, any_masked, coal_on;

  // Only the low bits of the write data are meaningful for each register.
  logic unused_pwdata;
  assign unused_pwdata = ^pwdata;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = intr_src;
    end else begin : g_sync
      logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values; blocking here would collapse the synchroniser chain.
      always_ff @(posedge pclk or negedge n_p_reset) begin
        if (!n_p_reset) begin
          for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
          sync_q[0] <= intr_src;
          for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign evt        = (mode_q & s) | (~mode_q & s & ~s_d);
  // A clear-all right after an event is dropped so the event it raced cannot be lost.
  assign clr_vec    = (intr_clr_sel ? pwdata[NUM_SRC-1:0] : '0)
                    | {NUM_SRC{clear_interrupt & ~interrupt_set}};
  assign ev_en      = |(evt & en_q);
  assign any_masked = |(raw_q & en_q);
  assign coal_on    = (thresh_q != '0);

  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      s_d           <= '0;
      raw_q         <= '0;
      en_q          <= '0;
      mode_q        <= '0;
      interrupt_set <= 1'b0;
      thresh_q      <= '0;
      tmo_q         <= '0;
    end else begin
      s_d           <= s;
      raw_q         <= (raw_q & ~clr_vec) | evt;
      interrupt_set <= |evt;
      if (intr_en_reg_sel)   en_q   <= pwdata[NUM_SRC-1:0];
      if (intr_mode_reg_sel) mode_q <= pwdata[NUM_SRC-1:0];
      if (coal_reg_sel) begin
        thresh_q <= pwdata[CNT_W-1:0];
        tmo_q    <= pwdata[16 +: TMO_W];
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    timer_n = timer_q;
    case (state_q)
      IDLE: begin
        if (coal_on && ev_en) begin
          state_n = ACCUM;
          cnt_n   = CNT_W'(1);
          timer_n = '0;
        end
      end
      ACCUM: begin
        if (ev_en && cnt_q != '1) cnt_n = cnt_q + 1'b1;
        if (timer_q != '1)        timer_n = timer_q + 1'b1;
        if (cnt_q >= thresh_q || (tmo_q != '0 && timer_q >= tmo_q)) begin
          state_n = FIRE;
        end else if (!any_masked) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      FIRE: begin
        if (!any_masked) begin
          state_n = IDLE;
          cnt_n   = '0;
          timer_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Reprogramming the coalescer restarts it cleanly from IDLE.
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
    end else if (coal_reg_sel) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      timer_q <= timer_n;
    end
  end

  assign interrupt_reg_out  = raw_q & en_q;
  assign interrupt_raw_out  = raw_q;
  assign interrupt_en_out   = en_q;
  assign interrupt_mode_out = mode_q;
  assign coal_cnt_out       = cnt_q;
  assign interrupt          = coal_on ? (state_q == FIRE) && any_masked : any_masked;

endmodule
